// File: rtl/scan_decoder_n_pkg.sv
// Shared encodings for scan_decoder_n: FSM state values and MODE strobe meanings.
package scan_decoder_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_n_if.sv
// Control/status bundle for scan_decoder_n.
//   master: drives e, mode, load, start, stop, a, dwell; observes d, idx, busy, wrap
//   slave : the decoder side of the same signals
interface scan_decoder_n_if #(
  parameter int ADDR_W  = 5,
  parameter int DWELL_W = 4
);
  logic                 e;
  logic                 mode;
  logic                 load;
  logic                 start;
  logic                 stop;
  logic [ADDR_W-1:0]    a;
  logic [DWELL_W-1:0]   dwell;
  logic [2**ADDR_W-1:0] d;
  logic [ADDR_W-1:0]    idx;
  logic                 busy;
  logic                 wrap;

  modport master (output e, mode, load, start, stop, a, dwell,
                  input  d, idx, busy, wrap);
  modport slave  (input  e, mode, load, start, stop, a, dwell,
                  output d, idx, busy, wrap);
endinterface

// File: rtl/scan_decoder_n_one_hot_decoder_n.sv
// Combinational ADDR_W-to-2^ADDR_W one-hot decoder with enable.
//   d : one-hot output, all zero when e=0
//   a : address
//   e : enable
module one_hot_decoder_n #(
  parameter int ADDR_W = 5
) (
  output logic [2**ADDR_W-1:0] d,
  input  logic [ADDR_W-1:0]    a,
  input  logic                 e
);

  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_line
    assign d[i] = e && (a == ADDR_W'(i));
  end

endmodule

// File: rtl/scan_decoder_n.sv
// Registered one-hot decoder with DIRECT (latch and hold) and SCAN (walk with dwell) modes.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : scan_decoder_n_if slave (strobes, address, dwell in; d/idx/busy/wrap out)
// Only the FSM, index register and dwell counter live here; d is decoded from the
// registered index, with e the only combinational input path to it.
module scan_decoder_n
  import scan_decoder_n_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DWELL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  scan_decoder_n_if.slave  bus
);

  localparam logic [ADDR_W-1:0] IDX_MAX = '1;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 wrap_q, wrap_d;
  logic                 dec_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
    end
  end

  // STOP beats everything; in SCAN the strobes are ignored so a scan cannot be restarted.
  // wrap defaults to 0 so it is a single-cycle pulse and drops while paused or stopped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (bus.e) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - DWELL_W'(1);
            end else begin
              idx_d  = idx_q + ADDR_W'(1);
              cnt_d  = dwell_q;
              wrap_d = (idx_q == IDX_MAX);
            end
          end
        end
        default: begin
          if (bus.load && bus.mode == MODE_DIRECT) begin
            idx_d   = bus.a;
            state_d = ST_HOLD;
          end else if (bus.start && bus.mode == MODE_SCAN) begin
            idx_d   = bus.a;
            cnt_d   = bus.dwell;
            dwell_d = bus.dwell;
            state_d = ST_SCAN;
          end
        end
      endcase
    end
  end

  assign dec_en = (state_q != ST_IDLE) && bus.e;

  one_hot_decoder_n #(.ADDR_W(ADDR_W)) u_dec (
    .d (bus.d),
    .a (idx_q),
    .e (dec_en)
  );

  assign bus.idx  = idx_q;
  assign bus.busy = (state_q == ST_SCAN);
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder_n.sv
// Scoreboard bench: stimulus pushes the expected outputs for each driven cycle,
// a monitor pops and compares them shortly after every rising edge.
module tb_scan_decoder_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_decoder_n_if #(.ADDR_W(5), .DWELL_W(4)) ifa ();
  scan_decoder_n_if #(.ADDR_W(3), .DWELL_W(4)) ifb ();

  scan_decoder_n #(.ADDR_W(5), .DWELL_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  scan_decoder_n #(.ADDR_W(3), .DWELL_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    bit          sel;
    logic [31:0] d;
    logic [4:0]  idx;
    logic        busy;
    logic        wrap;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_push = 0;

  task automatic tick(input bit sel, input logic [31:0] d, input int idx,
                      input logic b, input logic w);
    exp_t x;
    x.sel  = sel;
    x.d    = d;
    x.idx  = idx[4:0];
    x.busy = b;
    x.wrap = w;
    x.id   = n_push;
    n_push++;
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  task automatic ta(input logic [31:0] d, input int idx, input logic b, input logic w);
    tick(1'b0, d, idx, b, w);
  endtask

  task automatic check_zero(input string name);
    n_chk++;
    if (ifa.d !== '0 || ifa.idx !== '0 || ifa.busy !== 1'b0 || ifa.wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: d=%h idx=%0d busy=%b wrap=%b, expected all zero",
               name, ifa.d, ifa.idx, ifa.busy, ifa.wrap);
    end
  endtask

  // Monitor
  initial begin
    exp_t x;
    logic [31:0] ad;
    logic [4:0]  ai;
    logic        ab, aw;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        if (x.sel) begin
          ad = {24'b0, ifb.d}; ai = {2'b0, ifb.idx}; ab = ifb.busy; aw = ifb.wrap;
        end else begin
          ad = ifa.d; ai = ifa.idx; ab = ifa.busy; aw = ifa.wrap;
        end
        n_chk++;
        if (ad !== x.d || ai !== x.idx || ab !== x.busy || aw !== x.wrap) begin
          n_fail++;
          $display("FAIL %s_cyc%0d: d=%h idx=%0d busy=%b wrap=%b, expected d=%h idx=%0d busy=%b wrap=%b",
                   x.sel ? "a3" : "a5", x.id, ad, ai, ab, aw, x.d, x.idx, x.busy, x.wrap);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    ifa.e = 0; ifa.mode = 0; ifa.load = 0; ifa.start = 0; ifa.stop = 0; ifa.a = '0; ifa.dwell = '0;
    ifb.e = 0; ifb.mode = 0; ifb.load = 0; ifb.start = 0; ifb.stop = 0; ifb.a = '0; ifb.dwell = '0;
    #1;
    check_zero("reset_hold");
    @(negedge clk); #1;
    rst = 1'b0;

    // Released, no strobes: everything stays zero
    ta(32'h0, 0, 0, 0);
    ta(32'h0, 0, 0, 0);
    ifa.e = 1;
    ta(32'h0, 0, 0, 0);

    // DIRECT load of 19, then E gating
    ifa.mode = 0; ifa.a = 5'd19; ifa.load = 1;
    ta(32'h0008_0000, 19, 0, 0);
    ifa.load = 0;
    ta(32'h0008_0000, 19, 0, 0);
    ifa.e = 0;
    ta(32'h0, 19, 0, 0);
    ifa.e = 1;
    ta(32'h0008_0000, 19, 0, 0);
    // Mode-mismatched strobes are ignored
    ifa.mode = 1; ifa.a = 5'd5; ifa.load = 1;
    ta(32'h0008_0000, 19, 0, 0);
    ifa.load = 0; ifa.mode = 0; ifa.start = 1;
    ta(32'h0008_0000, 19, 0, 0);
    ifa.start = 0;

    // SCAN from 30 with dwell 2 (3 cycles per position), through the wrap
    ifa.mode = 1; ifa.a = 5'd30; ifa.dwell = 4'd2; ifa.start = 1;
    ta(32'h4000_0000, 30, 1, 0);
    ifa.start = 0; ifa.dwell = 4'd9;   // dwell is latched on START only
    ta(32'h4000_0000, 30, 1, 0);
    ta(32'h4000_0000, 30, 1, 0);
    ta(32'h8000_0000, 31, 1, 0);
    ta(32'h8000_0000, 31, 1, 0);
    ta(32'h8000_0000, 31, 1, 0);
    ta(32'h0000_0001, 0, 1, 1);
    ta(32'h0000_0001, 0, 1, 0);
    ta(32'h0000_0001, 0, 1, 0);
    for (int i = 1; i < 7; i++)
      for (int k = 0; k < 3; k++)
        ta(32'h1 << i, i, 1, 0);

    // Pause at index 7 with one dwell cycle left
    ta(32'h0000_0080, 7, 1, 0);
    ta(32'h0000_0080, 7, 1, 0);
    ifa.e = 0;
    for (int k = 0; k < 5; k++) ta(32'h0, 7, 1, 0);
    ifa.e = 1;
    ta(32'h0000_0080, 7, 1, 0);
    ta(32'h0000_0100, 8, 1, 0);

    // In SCAN: LOAD and START ignored; START+STOP stops
    ifa.mode = 0; ifa.a = 5'd3; ifa.load = 1;
    ta(32'h0000_0100, 8, 1, 0);
    ifa.load = 0; ifa.mode = 1; ifa.a = 5'd20; ifa.start = 1;
    ta(32'h0000_0100, 8, 1, 0);
    ifa.stop = 1;
    ta(32'h0, 8, 0, 0);
    ifa.stop = 0; ifa.start = 0;
    ta(32'h0, 8, 0, 0);

    // DWELL=0 scan across the wrap, then STOP while WRAP is high
    ifa.a = 5'd31; ifa.dwell = 4'd0; ifa.start = 1;
    ta(32'h8000_0000, 31, 1, 0);
    ifa.start = 0;
    ta(32'h0000_0001, 0, 1, 1);
    ifa.stop = 1;
    ta(32'h0, 0, 0, 0);
    ifa.stop = 0;

    // Reset in the middle of a scan clears outputs immediately
    ifa.a = 5'd10; ifa.dwell = 4'd3; ifa.start = 1;
    ta(32'h0000_0400, 10, 1, 0);
    ifa.start = 0;
    ta(32'h0000_0400, 10, 1, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_zero("reset_mid_scan");
    @(negedge clk); #1;
    rst = 1'b0;
    ta(32'h0, 0, 0, 0);
    ta(32'h0, 0, 0, 0);

    // ADDR_W=3 instance, DWELL=0 from 6
    ifb.e = 1; ifb.mode = 1; ifb.a = 3'd6; ifb.dwell = 4'd0; ifb.start = 1;
    tick(1'b1, 32'h40, 6, 1, 0);
    ifb.start = 0;
    tick(1'b1, 32'h80, 7, 1, 0);
    tick(1'b1, 32'h01, 0, 1, 1);
    tick(1'b1, 32'h02, 1, 1, 0);

    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
